// File: rtl/ws28xx_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ws28xx_pkg: shared WS28xx timing defaults and receiver state type     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package ws28xx_pkg;

  localparam int c_T_HMIN      = 20;
  localparam int c_T_THR       = 120;
  localparam int c_T_HMAX      = 400;
  localparam int c_T_RST       = 10000;
  localparam int c_FIFO_DEPTH  = 4;
  localparam int c_PIX_W       = 24;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    IDLE = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/ws28xx_rx_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ws28xx_rx_if: serial line, pixel stream and status of the receiver    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface ws28xx_rx_if;
  import ws28xx_pkg::*;

  logic                 ws28xx_i;
  logic [c_PIX_W-1:0]   pixel_o;
  logic                 valid_o;
  logic                 ready_i;
  logic                 frame_o;
  logic                 err_o;
  logic                 ovf_o;

  modport master (
    input  ws28xx_i, ready_i,
    output pixel_o, valid_o, frame_o, err_o, ovf_o
  );

  modport slave (
    output ws28xx_i, ready_i,
    input  pixel_o, valid_o, frame_o, err_o, ovf_o
  );
endinterface
`default_nettype wire

// File: rtl/ws28xx_rx_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ws28xx_rx_fifo: pixel FIFO with registered head word and sticky ovf   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module ws28xx_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_push,
  input  wire logic [WIDTH-1:0] i_data,
  input  wire logic             i_pop,
  output logic      [WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_ovf
);

  localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW:0]    r_wr;
  logic [c_AW:0]    r_rd;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_ovf;

  logic             w_full;
  logic             w_pop;
  logic             w_wr_en;
  logic [c_AW:0]    w_wr_next;
  logic [c_AW:0]    w_rd_next;

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign w_full    = (r_wr[c_AW] != r_rd[c_AW]) && (r_wr[c_AW-1:0] == r_rd[c_AW-1:0]);
  assign w_pop     = i_pop && r_valid;
  assign w_wr_en   = i_push && (!w_full || w_pop);
  assign w_wr_next = r_wr + {{c_AW{1'b0}}, w_wr_en};
  assign w_rd_next = r_rd + {{c_AW{1'b0}}, w_pop};

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr[c_AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_wr    <= w_wr_next;
      r_rd    <= w_rd_next;
      r_valid <= (w_wr_next != w_rd_next);
      // Head register bypasses the array when the word being written becomes the head
      if (w_wr_next != w_rd_next) begin
        r_data <= (w_wr_en && (r_wr[c_AW-1:0] == w_rd_next[c_AW-1:0]))
                  ? i_data : r_mem[w_rd_next[c_AW-1:0]];
      end
      if (i_push && w_full && !w_pop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: rtl/ws28xx_rx.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ws28xx_rx: WS28xx NRZ line decoder into 24-bit pixels + frame gaps    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module ws28xx_rx
  import ws28xx_pkg::*;
#(
  parameter int T_HMIN     = c_T_HMIN,
  parameter int T_THR      = c_T_THR,
  parameter int T_HMAX     = c_T_HMAX,
  parameter int T_RST      = c_T_RST,
  parameter int FIFO_DEPTH = c_FIFO_DEPTH
) (
  input  wire logic   hclk_i,
  input  wire logic   hresetn_i,
  ws28xx_rx_if.master bus
);

  // r_cnt holds width-1 on the edge cycle; a running low shows width-2 one cycle early
  localparam logic [15:0] c_HMIN_LIM = 16'(T_HMIN - 1);
  localparam logic [15:0] c_THR_LIM  = 16'(T_THR - 1);
  localparam logic [15:0] c_HMAX_LIM = 16'(T_HMAX - 1);
  localparam logic [15:0] c_RST_LIM  = 16'(T_RST - 2);

  logic         r_sync1;
  logic         r_sync2;
  logic         r_prev;
  logic [15:0]  r_cnt;
  rx_state_t    r_state;
  logic [4:0]   r_bit_cnt;
  logic [23:0]  r_shift;
  logic         r_push;
  logic         r_frame;
  logic         r_err;

  logic         w_rise;
  logic         w_fall;

  assign w_rise = r_sync2 && !r_prev;
  assign w_fall = !r_sync2 && r_prev;

  always_ff @(posedge hclk_i or negedge hresetn_i) begin
    if (!hresetn_i) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= bus.ws28xx_i;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (w_rise || w_fall) begin
        r_cnt <= '0;
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge hclk_i or negedge hresetn_i) begin
    if (!hresetn_i) begin
      r_state   <= SYNC;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_push    <= 1'b0;
      r_frame   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_push  <= 1'b0;
      r_frame <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        // The fall cycle still carries the stale high count, so it never qualifies as gap
        SYNC: if (!r_sync2 && !w_fall && r_cnt >= c_RST_LIM) r_state <= IDLE;
        IDLE: if (w_rise) r_state <= HIGH;
        HIGH: begin
          if (w_fall) begin
            if (r_cnt < c_HMIN_LIM) begin
              r_err     <= 1'b1;
              r_bit_cnt <= '0;
              r_state   <= SYNC;
            end else begin
              r_shift <= {r_shift[22:0], (r_cnt >= c_THR_LIM)};
              r_state <= LOW;
              if (r_bit_cnt == 5'd23) begin
                r_bit_cnt <= '0;
                r_push    <= 1'b1;
              end else begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
          end else if (r_cnt >= c_HMAX_LIM) begin
            r_err     <= 1'b1;
            r_bit_cnt <= '0;
            r_state   <= SYNC;
          end
        end
        LOW: begin
          if (w_rise) begin
            r_state <= HIGH;
          end else if (r_cnt >= c_RST_LIM) begin
            r_frame   <= 1'b1;
            r_err     <= (r_bit_cnt != 5'd0);
            r_bit_cnt <= '0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= SYNC;
      endcase
    end
  end

  ws28xx_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (24)
  ) u_fifo (
    .clk     (hclk_i),
    .rst_n   (hresetn_i),
    .i_push  (r_push),
    .i_data  (r_shift),
    .i_pop   (bus.ready_i),
    .o_data  (bus.pixel_o),
    .o_valid (bus.valid_o),
    .o_ovf   (bus.ovf_o)
  );

  assign bus.frame_o = r_frame;
  assign bus.err_o   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ws28xx_rx.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_ws28xx_rx: directed + random line stimulus against pixel queue     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_ws28xx_rx;
  import ws28xx_pkg::*;

  localparam int TB_T_RST = 1000;
  localparam int LOW_W    = 20;
  localparam int H0       = 80;
  localparam int H1       = 170;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ws28xx_rx_if bus ();

  ws28xx_rx #(
    .T_HMIN     (c_T_HMIN),
    .T_THR      (c_T_THR),
    .T_HMAX     (c_T_HMAX),
    .T_RST      (TB_T_RST),
    .FIFO_DEPTH (c_FIFO_DEPTH)
  ) dut (
    .hclk_i    (clk),
    .hresetn_i (rst_n),
    .bus       (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [23:0] exp_q [$];
  bit          exp_ovf  = 1'b0;
  int          n_frame  = 0;
  int          n_err    = 0;
  int          n_both   = 0;
  int          err_cyc  = 0;
  int          cyc      = 0;
  int          f0, e0, b0, c0, d;
  logic [31:0] rnd;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  always begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      if (bus.valid_o && bus.ready_i) begin
        if (exp_q.size() == 0) chk("spurious_valid", 32'(bus.valid_o), 32'd0);
        else chk("pixel", {8'h0, bus.pixel_o}, {8'h0, exp_q.pop_front()});
      end
      if (bus.frame_o) n_frame++;
      if (bus.err_o) begin
        n_err++;
        err_cyc = cyc;
      end
      if (bus.frame_o && bus.err_o) n_both++;
    end
  end

  // Sends the top n bits of w; the decoded word follows from the width thresholds alone
  task automatic send_bits(input logic [23:0] w, input int n, input int h0, input int h1,
                           input int last_low, input bit chk_lat);
    logic [23:0] dec;
    int h;
    dec = '0;
    for (int i = 0; i < n; i++) begin
      h = w[23-i] ? h1 : h0;
      dec[23-i] = (h >= c_T_THR);
      bus.ws28xx_i = 1'b1;
      tick(h);
      bus.ws28xx_i = 1'b0;
      if (i == 23) begin
        if (exp_q.size() < c_FIFO_DEPTH) exp_q.push_back(dec);
        else exp_ovf = 1'b1;
      end
      if (i == 23 && chk_lat) begin
        tick(3);
        #1;
        chk("lat_valid_early", 32'(bus.valid_o), 32'd0);
        tick(1);
        #1;
        chk("lat_valid", 32'(bus.valid_o), 32'd1);
        chk("lat_pixel", {8'h0, bus.pixel_o}, {8'h0, dec});
        tick(last_low - 4);
      end else begin
        tick((i == n - 1) ? last_low : LOW_W);
      end
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_pixel"}, {8'h0, bus.pixel_o}, 32'd0);
    chk({tag, "_valid"}, 32'(bus.valid_o), 32'd0);
    chk({tag, "_frame"}, 32'(bus.frame_o), 32'd0);
    chk({tag, "_err"},   32'(bus.err_o),   32'd0);
    chk({tag, "_ovf"},   32'(bus.ovf_o),   32'd0);
  endtask

  initial begin
    bus.ws28xx_i = 1'b0;
    bus.ready_i  = 1'b1;
    rst_n        = 1'b0;
    tick(3);
    #1;
    chk_outputs_zero("reset");
    tick(1);
    rst_n = 1'b1;

    // Leading gap, known pixel with latency check, two random pixels, closing gap
    tick(TB_T_RST + 10);
    f0 = n_frame; e0 = n_err;
    send_bits(24'hAABBCC, 24, H0, H1, LOW_W, 1'b1);
    rnd = $urandom;
    send_bits(rnd[23:0], 24, H0, H1, LOW_W, 1'b0);
    tick(TB_T_RST + 10);
    chk("basic_frame", 32'(n_frame - f0), 32'd1);
    chk("basic_err", 32'(n_err - e0), 32'd0);
    chk("basic_drained", 32'(exp_q.size()), 32'd0);

    // Stalled consumer: fifth pixel overflows, first four survive in order
    bus.ready_i = 1'b0;
    for (int k = 1; k <= 5; k++) send_bits(24'(k), 24, H0, H1, LOW_W, 1'b0);
    tick(2);
    #1;
    chk("ovf_set", 32'(bus.ovf_o), 32'(exp_ovf));
    chk("ovf_valid", 32'(bus.valid_o), 32'd1);
    chk("ovf_head", {8'h0, bus.pixel_o}, {8'h0, exp_q[0]});
    bus.ready_i = 1'b1;
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) tick(1);
    tick(2);
    #1;
    chk("ovf_drained", 32'(exp_q.size()), 32'd0);
    chk("ovf_valid_low", 32'(bus.valid_o), 32'd0);

    // Short glitch mid-word, resync, then a clean pixel
    f0 = n_frame; e0 = n_err;
    rnd = $urandom;
    send_bits(rnd[23:0], 8, H0, H1, LOW_W, 1'b0);
    bus.ws28xx_i = 1'b1;
    tick(10);
    bus.ws28xx_i = 1'b0;
    tick(TB_T_RST + 10);
    chk("glitch_err", 32'(n_err - e0), 32'd1);
    chk("glitch_frame", 32'(n_frame - f0), 32'd0);
    send_bits(24'h123456, 24, H0, H1, LOW_W, 1'b0);

    // Partial word closed by a gap
    f0 = n_frame; e0 = n_err; b0 = n_both;
    send_bits(24'hFFF000, 12, H0, H1, TB_T_RST + 10, 1'b0);
    chk("partial_err", 32'(n_err - e0), 32'd1);
    chk("partial_frame", 32'(n_frame - f0), 32'd1);
    chk("partial_same_cycle", 32'(n_both - b0), 32'd1);

    // Over-long high pulse
    f0 = n_frame; e0 = n_err;
    bus.ws28xx_i = 1'b1;
    c0 = cyc;
    tick(500);
    bus.ws28xx_i = 1'b0;
    tick(TB_T_RST + 10);
    d = err_cyc - c0;
    chk("hmax_err", 32'(n_err - e0), 32'd1);
    chk("hmax_timing", 32'(d >= 398 && d <= 408), 32'd1);
    chk("hmax_no_frame", 32'(n_frame - f0), 32'd0);

    // Width boundaries, gap one short of T_RST, gap exactly T_RST
    f0 = n_frame; e0 = n_err;
    rnd = $urandom;
    send_bits(rnd[23:0], 24, c_T_THR - 1, c_T_THR, TB_T_RST - 1, 1'b0);
    rnd = $urandom;
    send_bits(rnd[23:0], 24, c_T_HMIN, c_T_THR, TB_T_RST, 1'b0);
    rnd = $urandom;
    send_bits(rnd[23:0], 24, H0, H1, TB_T_RST + 10, 1'b0);
    chk("bound_frames", 32'(n_frame - f0), 32'd2);
    chk("bound_err", 32'(n_err - e0), 32'd0);

    // Reset asserted inside bit 10
    rnd = $urandom;
    send_bits(rnd[23:0], 10, H0, H1, LOW_W, 1'b0);
    bus.ws28xx_i = 1'b1;
    tick(40);
    rst_n = 1'b0;
    tick(1);
    #1;
    chk_outputs_zero("midreset");
    tick(2);
    rst_n = 1'b1;
    f0 = n_frame; e0 = n_err;
    tick(40);
    bus.ws28xx_i = 1'b0;
    tick(TB_T_RST + 10);
    send_bits(24'h00FF00, 24, H0, H1, TB_T_RST + 10, 1'b0);
    chk("post_reset_frame", 32'(n_frame - f0), 32'd1);
    chk("post_reset_err", 32'(n_err - e0), 32'd0);
    chk("post_reset_ovf", 32'(bus.ovf_o), 32'd0);
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
